// File: rtl/rd_ctrl_level.sv
// rtl/rd_ctrl_level.sv - read-side pointer, flag and fill-level control for an async FIFO
module rd_ctrl_level #(
  parameter int ADDR_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   w_ptr,
  output logic [ADDR_WIDTH:0]   r_ptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  rack,
  output logic                  runderflow
);

  localparam logic [ADDR_WIDTH:0] AE_TH = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rbin_nxt;
  logic [ADDR_WIDTH:0] rgray_nxt;
  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] wq;
  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] rlevel_nxt;

  assign rack      = rinc & ~rempty;
  assign rbin_nxt  = rbin + {{ADDR_WIDTH{1'b0}}, rack};
  assign rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
  assign raddr     = rbin[ADDR_WIDTH-1:0];
  assign wq        = sync_q[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of itself and every bit above it.
  always_comb begin
    wbin = '0;
    wbin[ADDR_WIDTH] = wq[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ wq[i];
    end
  end

  assign rlevel_nxt = wbin - rbin_nxt;

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= w_ptr;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Flags are computed from the post-read pointer so empty asserts on the consuming edge.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rbin       <= '0;
      r_ptr      <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin    <= rbin_nxt;
      r_ptr   <= rgray_nxt;
      rempty  <= (rgray_nxt == wq);
      raempty <= (rlevel_nxt <= AE_TH);
      rlevel  <= rlevel_nxt;
      if (rinc && rempty) begin
        runderflow <= 1'b1;
      end
    end
  end

endmodule
